// File: rtl/reg_xfer_sequencer_if.sv
// rtl/reg_xfer_sequencer_if.sv - command handshake and strobe/result bundle for reg_xfer_sequencer
interface reg_xfer_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [2:0]        cmd_src;
   logic [2:0]        cmd_dst;
   logic [DATA_W-1:0] cmd_imm;
   logic [7:0]        write_en;
   logic [7:0]        read_en;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              cmd_err;
   logic              busy;

   modport master (
      output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      input  cmd_ready, write_en, read_en, out_data, out_valid, cmd_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      output cmd_ready, write_en, read_en, out_data, out_valid, cmd_err, busy
   );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// rtl/reg_xfer_sequencer.sv - register-transfer sequencer feeding the 8-entry register file
// One command at a time becomes one EXEC cycle of one-hot strobes, followed by a bus turnaround gap.
module reg_xfer_sequencer #(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   reg_xfer_sequencer_if.slave ifc,
   inout  wire  [DATA_W-1:0]   cpu_bus
);
   typedef enum logic [1:0] {IDLE, EXEC, GAP} state_t;

   localparam logic [1:0] OP_MOV   = 2'd0;
   localparam logic [1:0] OP_LDI   = 2'd1;
   localparam logic [1:0] OP_ACC   = 2'd2;
   localparam logic [1:0] OP_STORE = 2'd3;
   localparam logic [1:0] GAP_LAST = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

   state_t            state;
   logic [1:0]        gap_cnt;
   logic [1:0]        op_q;
   logic              bus_oe;
   logic [DATA_W-1:0] bus_data;
   logic              accept;
   logic              illegal;

   // The accumulator input is not on the bus, so MOV/LDI may never target it.
   assign illegal = ((ifc.cmd_op == OP_MOV) || (ifc.cmd_op == OP_LDI)) && (ifc.cmd_dst == 3'd7);

   assign ifc.cmd_ready = (state == IDLE)
                       || ((state == GAP) && (gap_cnt == GAP_LAST))
                       || ((state == EXEC) && (GAP_CYCLES == 0));
   assign accept   = ifc.cmd_valid && ifc.cmd_ready;
   assign ifc.busy = (state != IDLE);
   assign cpu_bus  = bus_oe ? bus_data : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         gap_cnt       <= 2'd0;
         op_q          <= OP_MOV;
         bus_oe        <= 1'b0;
         bus_data      <= '0;
         ifc.write_en  <= 8'd0;
         ifc.read_en   <= 8'd0;
         ifc.out_data  <= '0;
         ifc.out_valid <= 1'b0;
         ifc.cmd_err   <= 1'b0;
      end else begin
         ifc.write_en  <= 8'd0;
         ifc.read_en   <= 8'd0;
         bus_oe        <= 1'b0;
         ifc.out_valid <= 1'b0;
         ifc.cmd_err   <= 1'b0;

         // STORE samples the bus on the edge that closes its EXEC cycle.
         if ((state == EXEC) && (op_q == OP_STORE)) begin
            ifc.out_data  <= cpu_bus;
            ifc.out_valid <= 1'b1;
         end

         if (accept) begin
            gap_cnt <= 2'd0;
            if (illegal) begin
               ifc.cmd_err <= 1'b1;
               state       <= IDLE;
            end else begin
               state <= EXEC;
               op_q  <= ifc.cmd_op;
               case (ifc.cmd_op)
                  OP_MOV: begin
                     ifc.read_en  <= 8'd1 << ifc.cmd_src;
                     ifc.write_en <= 8'd1 << ifc.cmd_dst;
                  end
                  OP_LDI: begin
                     ifc.write_en <= 8'd1 << ifc.cmd_dst;
                     bus_oe       <= 1'b1;
                     bus_data     <= ifc.cmd_imm;
                  end
                  OP_ACC: begin
                     ifc.write_en <= 8'h80;
                  end
                  default: begin
                     ifc.read_en <= 8'd1 << ifc.cmd_src;
                  end
               endcase
            end
         end else begin
            case (state)
               EXEC: begin
                  gap_cnt <= 2'd0;
                  if (GAP_CYCLES == 0) state <= IDLE;
                  else                 state <= GAP;
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST) state <= IDLE;
                  else                     gap_cnt <= gap_cnt + 2'd1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb/tb_reg_xfer_sequencer.sv - scoreboard bench for reg_xfer_sequencer at GAP_CYCLES 1, 0 and 3
module tb_reg_xfer_sequencer;
   localparam int DW = 8;

   typedef struct {
      int         dut;
      int         cyc;
      logic       err;
      logic [7:0] we;
      logic [7:0] re;
      logic       drv;
      logic [7:0] bus;
   } exp_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } oexp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int last_acc = 0;
   int sel = 1;

   logic          c_valid = 1'b0;
   logic [1:0]    c_op = 2'd0;
   logic [2:0]    c_src = 3'd0;
   logic [2:0]    c_dst = 3'd0;
   logic [DW-1:0] c_imm = '0;
   logic          tb_bus_en = 1'b1;
   logic [DW-1:0] tb_bus_val = 8'h3C;

   exp_t  sq[$];
   oexp_t oq[$];

   reg_xfer_sequencer_if #(.DATA_W(DW)) if1 ();
   reg_xfer_sequencer_if #(.DATA_W(DW)) if0 ();
   reg_xfer_sequencer_if #(.DATA_W(DW)) if3 ();
   wire [DW-1:0] bus1;
   wire [DW-1:0] bus0;
   wire [DW-1:0] bus3;

   // Register-file side of the main bus; lets the bench see whether the DUT releases it.
   assign bus1 = tb_bus_en ? tb_bus_val : {DW{1'bz}};

   assign if1.cmd_valid = c_valid && (sel == 1);
   assign if0.cmd_valid = c_valid && (sel == 0);
   assign if3.cmd_valid = c_valid && (sel == 3);
   assign if1.cmd_op = c_op;  assign if1.cmd_src = c_src; assign if1.cmd_dst = c_dst; assign if1.cmd_imm = c_imm;
   assign if0.cmd_op = c_op;  assign if0.cmd_src = c_src; assign if0.cmd_dst = c_dst; assign if0.cmd_imm = c_imm;
   assign if3.cmd_op = c_op;  assign if3.cmd_src = c_src; assign if3.cmd_dst = c_dst; assign if3.cmd_imm = c_imm;

   reg_xfer_sequencer #(.DATA_W(DW), .GAP_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .ifc(if1.slave), .cpu_bus(bus1));
   reg_xfer_sequencer #(.DATA_W(DW), .GAP_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .ifc(if0.slave), .cpu_bus(bus0));
   reg_xfer_sequencer #(.DATA_W(DW), .GAP_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .ifc(if3.slave), .cpu_bus(bus3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_ready();
      case (sel)
         0:       return if0.cmd_ready;
         3:       return if3.cmd_ready;
         default: return if1.cmd_ready;
      endcase
   endfunction

   function automatic exp_t model(input int d, input logic [1:0] op, input logic [2:0] src,
                                  input logic [2:0] dst, input logic [7:0] imm);
      exp_t e;
      e.dut = d; e.cyc = 0; e.we = 8'd0; e.re = 8'd0; e.drv = 1'b0; e.bus = imm;
      e.err = ((op == 2'd0) || (op == 2'd1)) && (dst == 3'd7);
      if (!e.err) begin
         case (op)
            2'd0: begin e.re[src] = 1'b1; e.we[dst] = 1'b1; end
            2'd1: begin e.we[dst] = 1'b1; e.drv = 1'b1; end
            2'd2: e.we[7] = 1'b1;
            default: e.re[src] = 1'b1;
         endcase
      end
      return e;
   endfunction

   task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [7:0] imm, input bit hold);
      exp_t e;
      int   n = 0;
      logic rdy = 1'b0;
      c_op = op; c_src = src; c_dst = dst; c_imm = imm; c_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = sel_ready();
         n++;
      end while (!rdy && n < 50);
      chk("accept_timeout", 32'(rdy), 1);
      if (rdy) begin
         e = model(sel, op, src, dst, imm);
         e.cyc = cyc + 1;
         sq.push_back(e);
         if (op == 2'd3) oq.push_back('{cyc + 2, tb_bus_val});
         last_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (!hold) c_valid = 1'b0;
   endtask

   task automatic mon(input int d, input logic [7:0] we, input logic [7:0] re, input logic err,
                      input logic ov, input logic [7:0] od, input logic [7:0] bus, input logic oe);
      exp_t  e;
      oexp_t o;
      if ((we != 8'd0) || (re != 8'd0) || err) begin
         chk("we_onehot", 32'($countones(we) <= 1), 1);
         chk("re_onehot", 32'($countones(re) <= 1), 1);
         chk("read_vs_drive", 32'((re != 8'd0) && oe), 0);
         chk("sb_nonempty", 32'(sq.size() != 0), 1);
         if (sq.size() != 0) begin
            e = sq.pop_front();
            chk("sb_dut", 32'(d), 32'(e.dut));
            chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            chk("sb_err", 32'(err), 32'(e.err));
            chk("sb_write_en", 32'(we), 32'(e.we));
            chk("sb_read_en", 32'(re), 32'(e.re));
            if (d == 1) begin
               if (e.drv) chk("bus_ldi", 32'(bus), 32'(e.bus));
               else       chk("bus_released", 32'(bus), 32'(tb_bus_val));
            end
         end
      end
      if (ov) begin
         chk("ob_nonempty", 32'(oq.size() != 0), 1);
         if (oq.size() != 0) begin
            o = oq.pop_front();
            chk("out_cycle", 32'(cyc), 32'(o.cyc));
            chk("out_data", 32'(od), 32'(o.data));
         end
      end
   endtask

   always @(negedge clk) if (reset) mon(1, if1.write_en, if1.read_en, if1.cmd_err, if1.out_valid, if1.out_data, bus1, dut1.bus_oe);
   always @(negedge clk) if (reset) mon(0, if0.write_en, if0.read_en, if0.cmd_err, if0.out_valid, if0.out_data, bus0, dut0.bus_oe);
   always @(negedge clk) if (reset) mon(3, if3.write_en, if3.read_en, if3.cmd_err, if3.out_valid, if3.out_data, bus3, dut3.bus_oe);

   initial begin
      int a0;
      int acc[4];

      // Reset held with a pending command: nothing may move.
      c_op = 2'd0; c_src = 3'd1; c_dst = 3'd2; c_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_write_en", 32'(if1.write_en), 0);
      chk("rst_read_en", 32'(if1.read_en), 0);
      chk("rst_out_data", 32'(if1.out_data), 0);
      chk("rst_out_valid", 32'(if1.out_valid), 0);
      chk("rst_cmd_err", 32'(if1.cmd_err), 0);
      chk("rst_busy", 32'(if1.busy), 0);
      chk("rst_bus_released", 32'(bus1), 32'h3C);
      c_valid = 1'b0;
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(if1.cmd_ready), 1);
      @(posedge clk); #1;

      // LDI r3 <= A5, then STORE r3.
      tb_bus_en = 1'b0;
      send(2'd1, 3'd0, 3'd3, 8'hA5, 1'b0);
      a0 = last_acc;
      @(posedge clk); #1;
      tb_bus_en = 1'b1; tb_bus_val = 8'hA5;
      send(2'd3, 3'd3, 3'd0, 8'h00, 1'b0);
      chk("store_accept_gap", 32'(last_acc - a0), 2);
      repeat (4) @(posedge clk); #1;
      chk("out_data_hold", 32'(if1.out_data), 32'hA5);

      // MOV r7 -> r0, then ACC_WR with the bus left to the register file.
      tb_bus_val = 8'h3C;
      send(2'd0, 3'd7, 3'd0, 8'h00, 1'b0);
      send(2'd2, 3'd0, 3'd0, 8'h00, 1'b0);
      repeat (4) @(posedge clk); #1;

      // Illegal MOV into the accumulator, then a normal MOV right after.
      send(2'd0, 3'd1, 3'd7, 8'h00, 1'b0);
      a0 = last_acc;
      chk("illegal_busy", 32'(if1.busy), 0);
      send(2'd0, 3'd2, 3'd4, 8'h00, 1'b0);
      chk("illegal_next_accept", 32'(last_acc - a0), 1);
      chk("illegal_out_data_kept", 32'(if1.out_data), 32'hA5);
      repeat (4) @(posedge clk); #1;

      // Streaming MOVs with valid held high: GAP_CYCLES=0 then GAP_CYCLES=3.
      sel = 0;
      for (int i = 0; i < 4; i++) begin
         send(2'd0, 3'(i), 3'(i + 1), 8'h00, i < 3);
         acc[i] = last_acc;
      end
      for (int i = 1; i < 4; i++) chk("gap0_rate", 32'(acc[i] - acc[i-1]), 1);
      repeat (4) @(posedge clk); #1;
      sel = 3;
      for (int i = 0; i < 4; i++) begin
         send(2'd0, 3'(6 - i), 3'(i), 8'h00, i < 3);
         acc[i] = last_acc;
      end
      for (int i = 1; i < 4; i++) chk("gap3_rate", 32'(acc[i] - acc[i-1]), 4);
      repeat (6) @(posedge clk); #1;

      // Asynchronous reset in the middle of an LDI EXEC cycle.
      sel = 1;
      tb_bus_en = 1'b0;
      send(2'd1, 3'd0, 3'd5, 8'h5A, 1'b0);
      @(negedge clk);
      #1 reset = 1'b0;
      tb_bus_en = 1'b1; tb_bus_val = 8'h3C;
      #1;
      chk("arst_write_en", 32'(if1.write_en), 0);
      chk("arst_bus_oe", 32'(dut1.bus_oe), 0);
      chk("arst_bus_released", 32'(bus1), 32'h3C);
      chk("arst_out_data", 32'(if1.out_data), 0);
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("arst_busy", 32'(if1.busy), 0);
      chk("arst_cmd_ready", 32'(if1.cmd_ready), 1);

      repeat (3) @(posedge clk); #1;
      chk("sb_drained", 32'(sq.size()), 0);
      chk("ob_drained", 32'(oq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/reg_xfer_sequencer.md
Name: reg_xfer_sequencer

Overview:
- Control stage directly upstream of the 8-entry register file.
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Turns each command into one-hot read_en/write_en strobes. For immediate loads it drives cpu_bus itself; for stores it samples cpu_bus.
- Guarantees at most one bus driver per cycle, with a programmable idle turnaround between transfers.

Parameters:
- DATA_W, 8, width of cpu_bus, cmd_imm and out_data.
- GAP_CYCLES, 1, idle bus-turnaround cycles after each EXEC cycle; legal range 0..3.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  0=MOV, 1=LDI, 2=ACC_WR, 3=STORE.
- cmd_src  input  3  source register index (MOV, STORE).
- cmd_dst  input  3  destination register index (MOV, LDI).
- cmd_imm  input  DATA_W  immediate value (LDI).
- cpu_bus  inout  DATA_W  shared register bus; driven only during LDI EXEC, otherwise high-Z.
- write_en  output  8  one-hot register write strobes; bit 7 = accumulator.
- read_en  output  8  one-hot register read strobes; bit 7 = accumulator.
- out_data  output  DATA_W  last value captured by STORE.
- out_valid  output  1  one-cycle pulse when out_data updates.
- cmd_err  output  1  one-cycle pulse on an illegal command.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, gap counter=0;
  - write_en, read_en, out_data, out_valid, cmd_err all 0;
  - cpu_bus released (high-Z).
- Reset asserted mid-EXEC kills strobes immediately; the partial transfer is not retried.
- States: IDLE, EXEC, GAP.
- cmd_ready = 1 in IDLE, and in GAP on its final cycle. With GAP_CYCLES=0, cmd_ready is also 1 in EXEC.
- Accept = cmd_valid & cmd_ready at a rising edge. The command is latched at that edge.
- Legal command on accept: next state is EXEC. All strobes and outputs are registered, so they are high exactly the one cycle after acceptance.
- EXEC strobes per op:
  - MOV: read_en[src]=1, write_en[dst]=1.
  - LDI: write_en[dst]=1; cpu_bus driven with the latched cmd_imm.
  - ACC_WR: write_en[7]=1 only; the accumulator captures reg_acc_in; no bus activity.
  - STORE: read_en[src]=1; out_data <= cpu_bus at the end-of-EXEC edge; out_valid=1 the following cycle for exactly one cycle.
- Illegal commands: MOV with dst=7, or LDI with dst=7 (the accumulator input is not the bus).
  - On accept: no strobes, state stays IDLE (or goes to IDLE from GAP).
  - cmd_err=1 the next cycle for exactly one cycle; the command is consumed.
- MOV with src==dst is legal (self-rewrite); both strobes assert.
- After EXEC:
  - GAP_CYCLES>0: GAP for exactly GAP_CYCLES cycles, all strobes 0, bus high-Z; then IDLE, unless a command is accepted on the final GAP cycle, which goes directly to EXEC.
  - GAP_CYCLES=0: back-to-back EXEC if a command is accepted in EXEC, otherwise IDLE.
- Throughput: one transfer per (1+GAP_CYCLES) cycles when cmd_valid is held high.
- Invariants (assert in bench):
  - popcount(read_en) <= 1 and popcount(write_en) <= 1 in every cycle.
  - read_en != 0 and bus-drive are never active in the same cycle.
  - Outside EXEC, all strobes are 0.
- cmd_* inputs are ignored when cmd_ready=0; the caller holds them stable until accepted.
- out_data holds its value until the next STORE.

Test Plan:
- Reset: hold reset=0 with cmd_valid=1 -> all strobes 0, cpu_bus=Z, cmd_ready=1 once reset=1.
- LDI dst=3 imm=0xA5, then STORE src=3 (GAP_CYCLES=1):
  - write_en=0x08 with cpu_bus=0xA5 in one cycle;
  - next command accepted 2 cycles after the first;
  - read_en=0x08; out_data=0xA5 with a 1-cycle out_valid.
- MOV src=7 dst=0 then ACC_WR -> read_en=0x80/write_en=0x01 in the same cycle; later write_en=0x80 alone with cpu_bus=Z.
- Illegal MOV dst=7 -> no strobes, cmd_err pulse of exactly 1 cycle, busy stays 0, next command accepted normally.
- GAP_CYCLES=0 and GAP_CYCLES=3 with cmd_valid held high over 4 MOVs:
  - GAP_CYCLES=0: EXEC strobes every cycle;
  - GAP_CYCLES=3: EXEC strobes every 4th cycle;
  - one-hot invariants hold throughout.
- Assert reset=0 during EXEC of LDI -> write_en=0 and cpu_bus=Z immediately (asynchronously, no clock edge needed); state IDLE after release; out_data=0.
